// File: rtl/absorb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : absorb_unit
//  Description : Sponge absorb stage. Mixes 64-bit message blocks into the
//                rate word of a 5x64 state, produces ciphertext/plaintext,
//                pads the final block and applies the finalization key XOR
//                before handing the state to the permutation.
//  Revision    : 1.0 - initial release
// ============================================================================

package absorb_unit_pkg;
  // Five 64-bit state words; index 0 is the rate word S0.
  typedef logic [4:0][63:0] type_state;
endpackage

module absorb_unit
  import absorb_unit_pkg::*;
(
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          start_i,
  input  logic          mode_decrypt_i,
  input  logic [63:0]   data_i,
  input  logic          data_valid_i,
  input  logic          last_i,
  input  logic [3:0]    nbytes_i,
  output logic          data_ready_o,
  input  logic [127:0]  key_i,
  input  type_state     state_i,
  input  logic          state_valid_i,
  output type_state     state_o,
  output logic          state_valid_o,
  output logic [63:0]   text_o,
  output logic          done_o,
  output logic [15:0]   blocks_o
);

  localparam logic [63:0] C_PAD_TOP = 64'h8000_0000_0000_0000;
  localparam logic [63:0] C_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [15:0] C_BLK_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_WAIT_PERM = 3'd2,
    ST_PAD_PERM  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t      r_fsm;
  state_t      w_fsm_nxt;

  type_state   r_s;
  type_state   r_state_out;
  type_state   w_out_state;
  logic        r_mode;
  logic [63:0] r_text;
  logic [63:0] w_out_text;
  logic        r_state_valid;
  logic        r_done;
  logic [15:0] r_blocks;

  logic        w_start;
  logic        w_perm_load;
  logic        w_out_load;
  logic        w_out_done;
  logic        w_blk_inc;

  logic        w_full;
  logic [5:0]  w_shift;
  logic [63:0] w_mask;
  logic [63:0] w_pad;
  logic [63:0] w_s0_xor_d;

  // Byte counts of 8 and above all describe a full block.
  assign w_full     = (nbytes_i >= 4'd8);
  assign w_shift    = {nbytes_i[2:0], 3'b000};
  // Mask keeps the top k bytes; pad bit sits just below them.
  assign w_mask     = ~(C_ONES >> w_shift);
  assign w_pad      = C_PAD_TOP >> w_shift;
  assign w_s0_xor_d = r_s[0] ^ data_i;

  assign data_ready_o  = (r_fsm == ST_WAIT_DATA);
  assign state_o       = r_state_out;
  assign state_valid_o = r_state_valid;
  assign text_o        = r_text;
  assign done_o        = r_done;
  assign blocks_o      = r_blocks;

  // FSM state register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state decode and the combinational value of the next output word.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_start     = 1'b0;
    w_perm_load = 1'b0;
    w_out_load  = 1'b0;
    w_out_done  = 1'b0;
    w_blk_inc   = 1'b0;
    w_out_state = r_s;
    w_out_text  = '0;

    case (r_fsm)
      ST_IDLE: begin
        if (start_i) begin
          w_start   = 1'b1;
          w_fsm_nxt = ST_WAIT_DATA;
        end
      end

      ST_WAIT_DATA: begin
        if (data_valid_i) begin
          w_out_load = 1'b1;
          w_blk_inc  = 1'b1;
          if (last_i && !w_full) begin
            // Partial final block: pad in place and finalize with the key.
            w_out_text = w_s0_xor_d & w_mask;
            if (r_mode) begin
              w_out_state[0] = ((data_i & w_mask) | (r_s[0] & ~w_mask)) ^ w_pad;
            end else begin
              w_out_state[0] = (r_s[0] ^ (data_i & w_mask)) ^ w_pad;
            end
            w_out_state[1] = r_s[1] ^ key_i[127:64];
            w_out_state[2] = r_s[2] ^ key_i[63:0];
            w_out_done     = 1'b1;
            w_fsm_nxt      = ST_DONE;
          end else begin
            // Full block; a full final block needs an extra padding block.
            w_out_text     = w_s0_xor_d;
            w_out_state[0] = r_mode ? data_i : w_s0_xor_d;
            w_fsm_nxt      = last_i ? ST_PAD_PERM : ST_WAIT_PERM;
          end
        end
      end

      ST_WAIT_PERM: begin
        if (state_valid_i) begin
          w_perm_load = 1'b1;
          w_fsm_nxt   = ST_WAIT_DATA;
        end
      end

      ST_PAD_PERM: begin
        if (state_valid_i) begin
          // Empty padding block absorbed directly into the returned state.
          w_out_load     = 1'b1;
          w_out_done     = 1'b1;
          w_out_state    = state_i;
          w_out_state[0] = state_i[0] ^ C_PAD_TOP;
          w_out_state[1] = state_i[1] ^ key_i[127:64];
          w_out_state[2] = state_i[2] ^ key_i[63:0];
          w_out_text     = '0;
          w_fsm_nxt      = ST_DONE;
        end
      end

      ST_DONE: begin
        w_fsm_nxt = ST_IDLE;
      end

      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  // Sponge state, output registers and saturating block counter.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_s           <= '0;
      r_mode        <= 1'b0;
      r_state_out   <= '0;
      r_text        <= '0;
      r_state_valid <= 1'b0;
      r_done        <= 1'b0;
      r_blocks      <= '0;
    end else begin
      r_state_valid <= w_out_load;
      r_done        <= w_out_done;
      if (w_start) begin
        r_s      <= state_i;
        r_mode   <= mode_decrypt_i;
        r_blocks <= '0;
      end
      if (w_perm_load) begin
        r_s <= state_i;
      end
      if (w_out_load) begin
        r_s         <= w_out_state;
        r_state_out <= w_out_state;
        r_text      <= w_out_text;
      end
      if (w_blk_inc && (r_blocks != C_BLK_MAX)) begin
        r_blocks <= r_blocks + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
